// File: rtl/gcd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : gcd_unit
//  Description : Iterative GCD engine. Operands A then B arrive serially on
//                data_in; repeated subtraction reduces them until equal (or
//                one is zero). done is high while the result sits on gcd_out.
//  Revision    : 1.0 - initial release
// ============================================================================
module gcd_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             done,
  output logic [WIDTH-1:0] gcd_out
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_CALC   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_done;

  // Datapath: comparator and the two subtractors feeding the A/B registers
  logic             w_a_eq_b;
  logic             w_a_gt_b;
  logic             w_a_zero;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_a_minus_b;
  logic [WIDTH-1:0] w_b_minus_a;

  assign w_a_eq_b    = (r_a == r_b);
  assign w_a_gt_b    = (r_a > r_b);
  assign w_a_zero    = (r_a == '0);
  assign w_b_zero    = (r_b == '0);
  // Only the branch whose minuend is the larger operand is ever used,
  // so neither difference wraps when it is selected.
  assign w_a_minus_b = r_a - r_b;
  assign w_b_minus_a = r_b - r_a;

  // Controller and operand registers; done is a registered Moore flag for DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD_A;
          end
        end
        S_LOAD_A: begin
          r_a     <= data_in;
          r_state <= S_LOAD_B;
        end
        S_LOAD_B: begin
          r_b     <= data_in;
          r_state <= S_CALC;
        end
        S_CALC: begin
          if (w_a_eq_b || w_b_zero) begin
            // A already holds the answer (covers GCD(0,0) = 0)
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (w_a_zero) begin
            // Move B into A so gcd_out presents the result
            r_a     <= r_b;
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (w_a_gt_b) begin
            r_a <= w_a_minus_b;
          end else begin
            r_b <= w_b_minus_a;
          end
        end
        S_DONE: begin
          // Hold the result until start is released; no auto-restart
          if (!start) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign done    = r_done;
  assign gcd_out = r_a;

endmodule
`default_nettype wire

// File: tb/tb_gcd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gcd_unit
//  Description : Self-checking bench for gcd_unit: vector table plus
//                hand-written reset, trace and start-hold sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_unit;

  localparam int WIDTH = 16;
  localparam int MAX_CALC = 300;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             done;
  logic [WIDTH-1:0] gcd_out;

  int checks;
  int errors;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] g;
    int               cyc;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  gcd_unit #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .done    (done),
    .gcd_out (gcd_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start an operation and feed both operands; returns 1 ns after the edge
  // that loads B (FSM now in CALC).
  task automatic load_ops(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit hold);
    @(negedge clk);
    start   = 1'b1;
    data_in = 16'hDEAD;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    data_in = a;
    @(posedge clk); #1;
    check("load_a", gcd_out, a);
    data_in = b;
    @(posedge clk); #1;
    data_in = 16'hBEEF;
    check("busy_done", done, 0);
  endtask

  // Count CALC edges until done rises, bounded by MAX_CALC
  task automatic wait_done(input bit toggle, output int cycles, output bit timed_out);
    cycles    = 0;
    timed_out = 1'b1;
    for (int i = 0; i < MAX_CALC; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      if (toggle) start = 1'($urandom_range(0, 1));
    end
  endtask

  // Release start for one edge and confirm the return to IDLE
  task automatic finish_op();
    start = 1'b0;
    @(posedge clk); #1;
    check("idle_after_done", done, 0);
  endtask

  int cyc;
  bit to;
  logic [WIDTH-1:0] trace [6];

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;

    vecs[0]  = '{a: 16'd48,    b: 16'd18,    g: 16'd6,     cyc: 5};
    vecs[1]  = '{a: 16'd25,    b: 16'd25,    g: 16'd25,    cyc: 1};
    vecs[2]  = '{a: 16'd0,     b: 16'd7,     g: 16'd7,     cyc: 1};
    vecs[3]  = '{a: 16'd9,     b: 16'd0,     g: 16'd9,     cyc: 1};
    vecs[4]  = '{a: 16'd0,     b: 16'd0,     g: 16'd0,     cyc: 1};
    vecs[5]  = '{a: 16'd17,    b: 16'd5,     g: 16'd1,     cyc: 7};
    vecs[6]  = '{a: 16'd100,   b: 16'd75,    g: 16'd25,    cyc: 4};
    vecs[7]  = '{a: 16'd12,    b: 16'd8,     g: 16'd4,     cyc: 3};
    vecs[8]  = '{a: 16'd7,     b: 16'd13,    g: 16'd1,     cyc: 8};
    vecs[9]  = '{a: 16'd65535, b: 16'd65535, g: 16'd65535, cyc: 1};
    vecs[10] = '{a: 16'd65535, b: 16'd0,     g: 16'd65535, cyc: 1};

    trace[0] = 16'd65; trace[1] = 16'd65; trace[2] = 16'd52;
    trace[3] = 16'd39; trace[4] = 16'd26; trace[5] = 16'd13;

    // Reset state
    #2;
    check("reset_done", done, 0);
    check("reset_gcd", gcd_out, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Cycle-accurate trace of GCD(143,78)
    load_ops(16'd143, 16'd78, 1'b0);
    check("trace_b_loaded_a", gcd_out, 143);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("trace_a_%0d", k), gcd_out, trace[k]);
      check($sformatf("trace_busy_%0d", k), done, 0);
    end
    @(posedge clk); #1;
    check("trace_done_edge10", done, 1);
    check("trace_gcd", gcd_out, 13);
    finish_op();

    // Table vectors back to back; odd entries toggle start during CALC
    for (int i = 0; i < NV; i++) begin
      load_ops(vecs[i].a, vecs[i].b, 1'b0);
      wait_done(i[0], cyc, to);
      check($sformatf("vec%0d_timeout", i), 32'(to), 0);
      check($sformatf("vec%0d_gcd", i), gcd_out, vecs[i].g);
      check($sformatf("vec%0d_cycles", i), cyc, vecs[i].cyc);
      finish_op();
    end

    // start held high throughout: DONE must persist with a stable result
    load_ops(16'd48, 16'd18, 1'b1);
    wait_done(1'b0, cyc, to);
    check("hold_timeout", 32'(to), 0);
    check("hold_gcd", gcd_out, 6);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("hold_done_%0d", k), done, 1);
      check($sformatf("hold_gcd_%0d", k), gcd_out, 6);
    end
    finish_op();

    // Asynchronous reset in the middle of CALC
    load_ops(16'd143, 16'd78, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_calc_a", gcd_out, 52);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_done", done, 0);
    check("async_rst_gcd", gcd_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_idle_done", done, 0);
    check("post_rst_idle_gcd", gcd_out, 0);

    // Fresh operation after reset
    load_ops(16'd17, 16'd5, 1'b0);
    wait_done(1'b0, cyc, to);
    check("post_rst_timeout", 32'(to), 0);
    check("post_rst_gcd", gcd_out, 1);
    check("post_rst_cycles", cyc, 7);
    finish_op();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
